// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and latency helpers
// for the iterative HI/LO multiply/divide unit.
package mdu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV_ITER,
        ST_DIV_FIX
    } mdu_state_e;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_ADD,
        ACC_SUB
    } mdu_acc_e;

    function automatic int div_lat(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: unsigned restoring divider, one quotient bit
// per cycle, WIDTH iterations after the start edge.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             last_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             run_q;
    logic             valid_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   trial;

    // Top bit of trial is the borrow: set means restore.
    assign sh     = {rem_q, quo_q[WIDTH-1]};
    assign trial  = sh - {1'b0, dvs_q};
    assign last_o = run_q && (cnt_q == CW'(1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
        end else if (flush_i) begin
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (start_i) begin
            run_q   <= 1'b1;
            valid_q <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            rem_q   <= '0;
            quo_q   <= dividend_i;
            dvs_q   <= divisor_i;
        end else if (run_q) begin
            rem_q <= trial[WIDTH] ? sh[WIDTH-1:0]
                                  : trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_q <= cnt_q - CW'(1);
            if (last_o) begin
                run_q   <= 1'b0;
                valid_q <= 1'b1;
            end
        end
    end

    assign valid_o = valid_q;
    assign quot_o  = quo_q;
    assign rem_o   = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: E-stage multiply/divide unit owning HI/LO.
// Define MDU_MACC_EN to build MADD/MADDU/MSUB/MSUBU.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] Data1,
    input  logic [WIDTH-1:0] Data2,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int W2 = 2 * WIDTH;

    mdu_state_e       state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CW-1:0]    cnt_q;
    logic [W2-1:0]    prod_q;
    logic             qneg_q;
    logic             rneg_q;

    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             sgn;
    logic             mthi;
    logic             mtlo;
    logic             div_go;
    logic [W2-1:0]    a_ext;
    logic [W2-1:0]    b_ext;
    logic [W2-1:0]    prod;
    logic [W2-1:0]    mul_res;
    logic [WIDTH-1:0] d1_abs;
    logic [WIDTH-1:0] d2_abs;
    logic             div_last;
    logic             div_valid;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
`ifdef MDU_MACC_EN
    mdu_acc_e         acc_op;
    mdu_acc_e         acc_q;
`endif

    assign accept = Start && !busy_q && !Flush;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        sgn    = 1'b0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
`ifdef MDU_MACC_EN
        acc_op = ACC_NONE;
`endif
        unique case (Op)
            OP_MULT: begin
                is_mul = 1'b1;
                sgn    = 1'b1;
            end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV: begin
                is_div = 1'b1;
                sgn    = 1'b1;
            end
            OP_DIVU: is_div = 1'b1;
            OP_MTHI: mthi = 1'b1;
            OP_MTLO: mtlo = 1'b1;
`ifdef MDU_MACC_EN
            OP_MADD: begin
                is_mul = 1'b1;
                sgn    = 1'b1;
                acc_op = ACC_ADD;
            end
            OP_MADDU: begin
                is_mul = 1'b1;
                acc_op = ACC_ADD;
            end
            OP_MSUB: begin
                is_mul = 1'b1;
                sgn    = 1'b1;
                acc_op = ACC_SUB;
            end
            OP_MSUBU: begin
                is_mul = 1'b1;
                acc_op = ACC_SUB;
            end
`endif
            default: ;
        endcase
    end

    // Sign-extending to 2*WIDTH makes the low half of one
    // unsigned product correct for both signednesses.
    assign a_ext = sgn ? {{WIDTH{Data1[WIDTH-1]}}, Data1}
                       : {{WIDTH{1'b0}}, Data1};
    assign b_ext = sgn ? {{WIDTH{Data2[WIDTH-1]}}, Data2}
                       : {{WIDTH{1'b0}}, Data2};
    assign prod  = a_ext * b_ext;

    assign d1_abs = (sgn && Data1[WIDTH-1]) ? -Data1 : Data1;
    assign d2_abs = (sgn && Data2[WIDTH-1]) ? -Data2 : Data2;
    assign div_go = accept && is_div && (Data2 != '0);

    mdu_div_core #(
        .WIDTH(WIDTH)
    ) u_div (
        .Clk       (Clk),
        .Reset     (Reset),
        .start_i   (div_go),
        .flush_i   (Flush),
        .dividend_i(d1_abs),
        .divisor_i (d2_abs),
        .last_o    (div_last),
        .valid_o   (div_valid),
        .quot_o    (quot),
        .rem_o     (rem)
    );

    assign q_fix = qneg_q ? -quot : quot;
    assign r_fix = rneg_q ? -rem : rem;

`ifdef MDU_MACC_EN
    always_comb begin
        mul_res = prod_q;
        unique case (acc_q)
            ACC_ADD: mul_res = {hi_q, lo_q} + prod_q;
            ACC_SUB: mul_res = {hi_q, lo_q} - prod_q;
            default: mul_res = prod_q;
        endcase
    end
`else
    assign mul_res = prod_q;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`ifdef MDU_MACC_EN
            acc_q   <= ACC_NONE;
`endif
        end else begin
            done_q <= 1'b0;
            if (busy_q && Flush) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (accept && mthi) hi_q <= Data1;
                        if (accept && mtlo) lo_q <= Data1;
                        if (accept && is_mul) begin
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
                            cnt_q   <= CW'(MUL_LAT - 1);
                            prod_q  <= prod;
`ifdef MDU_MACC_EN
                            acc_q   <= acc_op;
`endif
                        end
                        if (div_go) begin
                            state_q <= ST_DIV_ITER;
                            busy_q  <= 1'b1;
                            qneg_q  <= sgn && (Data1[WIDTH-1] ^ Data2[WIDTH-1]);
                            rneg_q  <= sgn && Data1[WIDTH-1];
                        end
                    end
                    ST_MUL: begin
                        if (cnt_q == '0) begin
                            {hi_q, lo_q} <= mul_res;
                            state_q      <= ST_IDLE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    ST_DIV_ITER: begin
                        if (div_last) state_q <= ST_DIV_FIX;
                    end
                    ST_DIV_FIX: begin
                        if (div_valid) begin
                            lo_q    <= q_fix;
                            hi_q    <= r_fix;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors for mdu_iter against an
// arithmetic reference model checked every cycle.
module tb_mdu_iter;

    localparam int MUL_LAT = 5;
    localparam int DIV_CYC = 33;

    localparam logic [3:0] T_NOP   = 4'd0;
    localparam logic [3:0] T_MULT  = 4'd1;
    localparam logic [3:0] T_MULTU = 4'd2;
    localparam logic [3:0] T_DIV   = 4'd3;
    localparam logic [3:0] T_DIVU  = 4'd4;
    localparam logic [3:0] T_MTHI  = 4'd5;
    localparam logic [3:0] T_MTLO  = 4'd6;
    localparam logic [3:0] T_MADD  = 4'd7;
    localparam logic [3:0] T_MADDU = 4'd8;
    localparam logic [3:0] T_MSUB  = 4'd9;
    localparam logic [3:0] T_MSUBU = 4'd10;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [3:0]  Op = T_NOP;
    logic [31:0] Data1 = '0;
    logic [31:0] Data2 = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // reference model state
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [3:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;

    mdu_iter #(
        .WIDTH  (32),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Start(Start),
        .Op   (Op),
        .Data1(Data1),
        .Data2(Data2),
        .Flush(Flush),
        .Busy (Busy),
        .Done (Done),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] result(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [63:0] acc);
        logic [63:0] ps;
        logic [63:0] pu;
        logic [31:0] q;
        logic [31:0] r;
        ps = longint'($signed(a)) * longint'($signed(b));
        pu = {32'd0, a} * {32'd0, b};
        case (op)
            T_MULT:  return ps;
            T_MULTU: return pu;
            T_MADD:  return acc + ps;
            T_MADDU: return acc + pu;
            T_MSUB:  return acc - ps;
            T_MSUBU: return acc - pu;
            T_DIVU: begin
                q = a / b;
                r = a % b;
                return {r, q};
            end
            T_DIV: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'd0, a};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: return acc;
        endcase
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_hi   = '0;
            m_lo   = '0;
            m_left = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left != 0) begin
                if (Flush) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        {m_hi, m_lo} = result(m_op, m_a, m_b, {m_hi, m_lo});
                        m_done = 1'b1;
                    end
                end
            end else if (Start && !Flush) begin
                m_op = Op;
                m_a  = Data1;
                m_b  = Data2;
                case (Op)
                    T_MTHI: m_hi = Data1;
                    T_MTLO: m_lo = Data1;
                    T_MULT, T_MULTU: m_left = MUL_LAT;
                    T_DIV, T_DIVU: if (Data2 != 0) m_left = DIV_CYC;
`ifdef MDU_MACC_EN
                    T_MADD, T_MADDU, T_MSUB, T_MSUBU: m_left = MUL_LAT;
`endif
                    default: ;
                endcase
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("busy", 64'(Busy), 64'(m_left != 0));
            check("done", 64'(Done), 64'(m_done));
            if (m_left == 0) begin
                check("hi", 64'(HI), 64'(m_hi));
                check("lo", 64'(LO), 64'(m_lo));
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          output int blen,
                          output bit dseen);
        Start = 1'b1;
        Op    = op;
        Data1 = a;
        Data2 = b;
        step();
        Start = 1'b0;
        Op    = T_NOP;
        Data1 = '0;
        Data2 = '0;
        blen  = 0;
        dseen = Done;
        while (Busy && blen < 100) begin
            blen++;
            step();
            if (Done) dseen = 1'b1;
        end
        if (Busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout op %0d: Busy stuck at 1", op);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bl;
        bit  dn;
        int  b;
        int  lim;

        step();
        step();
        chk_en = 1'b1;
        Reset  = 1'b0;
        check("rst_hi", 64'(HI), 64'h0);
        check("rst_lo", 64'(LO), 64'h0);
        check("rst_busy", 64'(Busy), 64'h0);
        check("rst_done", 64'(Done), 64'h0);

        run_op(T_MULT, 32'hFFFF_FFFE, 32'd3, bl, dn);
        check("mult_lat", 64'(bl), 64'd5);
        check("mult_done", 64'(dn), 64'd1);
        check("mult_hi", 64'(HI), 64'hFFFF_FFFF);
        check("mult_lo", 64'(LO), 64'hFFFF_FFFA);

        run_op(T_MULTU, 32'hFFFF_FFFE, 32'd3, bl, dn);
        check("multu_hi", 64'(HI), 64'h2);
        check("multu_lo", 64'(LO), 64'hFFFF_FFFA);

        run_op(T_DIV, 32'hFFFF_FFF9, 32'd2, bl, dn);
        check("div_lat", 64'(bl), 64'd33);
        check("div_done", 64'(dn), 64'd1);
        check("div_lo", 64'(LO), 64'hFFFF_FFFD);
        check("div_hi", 64'(HI), 64'hFFFF_FFFF);

        run_op(T_DIVU, 32'd100, 32'd7, bl, dn);
        check("divu_lo", 64'(LO), 64'd14);
        check("divu_hi", 64'(HI), 64'd2);

        run_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bl, dn);
        check("ovf_lo", 64'(LO), 64'h8000_0000);
        check("ovf_hi", 64'(HI), 64'h0);

        run_op(T_DIV, 32'd7, 32'hFFFF_FFFE, bl, dn);
        check("divneg_lo", 64'(LO), 64'hFFFF_FFFD);
        check("divneg_hi", 64'(HI), 64'd1);

        run_op(T_MTHI, 32'h1234, 32'd0, bl, dn);
        run_op(T_MTLO, 32'h5678, 32'd0, bl, dn);
        check("mt_busy", 64'(bl), 64'd0);
        run_op(T_DIV, 32'd99, 32'd0, bl, dn);
        check("dz_busy", 64'(bl), 64'd0);
        check("dz_done", 64'(dn), 64'd0);
        check("dz_hi", 64'(HI), 64'h1234);
        check("dz_lo", 64'(LO), 64'h5678);

        Start = 1'b1;
        Flush = 1'b1;
        Op    = T_MTLO;
        Data1 = 32'h77;
        step();
        Start = 1'b0;
        Flush = 1'b0;
        check("sf_lo", 64'(LO), 64'h5678);

        Start = 1'b1;
        Op    = T_DIVU;
        Data1 = 32'd1000;
        Data2 = 32'd3;
        step();
        Start = 1'b0;
        repeat (9) step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("fl_busy", 64'(Busy), 64'h0);
        check("fl_done", 64'(Done), 64'h0);
        check("fl_hi", 64'(HI), 64'h1234);
        check("fl_lo", 64'(LO), 64'h5678);
        run_op(T_MULT, 32'd7, 32'd6, bl, dn);
        check("pf_lat", 64'(bl), 64'd5);
        check("pf_lo", 64'(LO), 64'd42);
        check("pf_hi", 64'(HI), 64'd0);

        run_op(T_MTHI, 32'd0, 32'd0, bl, dn);
        run_op(T_MTLO, 32'd10, 32'd0, bl, dn);
        run_op(T_MADD, 32'd3, 32'd4, bl, dn);
`ifdef MDU_MACC_EN
        check("madd_lat", 64'(bl), 64'd5);
        check("madd_lo", 64'(LO), 64'd22);
        check("madd_hi", 64'(HI), 64'd0);
        run_op(T_MSUB, 32'd5, 32'd5, bl, dn);
        check("msub_hi", 64'(HI), 64'hFFFF_FFFF);
        check("msub_lo", 64'(LO), 64'hFFFF_FFFD);
`else
        check("madd_off_busy", 64'(bl), 64'd0);
        check("madd_off_done", 64'(dn), 64'd0);
        check("madd_off_lo", 64'(LO), 64'd10);
        check("madd_off_hi", 64'(HI), 64'd0);
`endif

        Start = 1'b1;
        Op    = T_DIVU;
        Data1 = 32'd100;
        Data2 = 32'd7;
        step();
        Start = 1'b0;
        b = int'(Busy);
        for (int i = 0; i < 2; i++) begin
            step();
            b += int'(Busy);
        end
        Start = 1'b1;
        Op    = T_MULT;
        Data1 = 32'd9;
        Data2 = 32'd9;
        step();
        Start = 1'b0;
        Op    = T_NOP;
        b += int'(Busy);
        lim = 0;
        while (Busy && lim < 100) begin
            step();
            b += int'(Busy);
            lim++;
        end
        check("ign_len", 64'(b), 64'd33);
        check("ign_lo", 64'(LO), 64'd14);
        check("ign_hi", 64'(HI), 64'd2);

        Start = 1'b1;
        Op    = T_DIV;
        Data1 = 32'd50;
        Data2 = 32'd3;
        step();
        Start = 1'b0;
        repeat (5) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("mrst_hi", 64'(HI), 64'h0);
        check("mrst_lo", 64'(LO), 64'h0);
        check("mrst_busy", 64'(Busy), 64'h0);

        run_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bl, dn);
        check("mu_max_hi", 64'(HI), 64'hFFFF_FFFE);
        check("mu_max_lo", 64'(LO), 64'h1);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
